div4_restoring: RTL

Sequential restoring divider that sits directly downstream of the team's 4-bit ripple subtractor and consumes its difference and borrow each cycle. It accepts a dividend/divisor pair on a start pulse and produces one quotient bit per cycle, MSB first. Results are presented with a one-cycle done pulse. The block is the first multi-cycle arithmetic unit in the datapath and shares the subtractor cells with the combinational stage.

---
 rtl/div_pkg.sv | 16 +
 rtl/sub_borrow.sv | 27 ++
 rtl/div4_restoring.sv | 130 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizes for the restoring divider
//   DIV_W       : operand width of the divider
//   CNT_W       : width of the iteration counter (0..DIV_W-1)
//   div_state_t : controller states
package div_pkg;

  localparam int DIV_W = 4;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/sub_borrow.sv
// rtl/sub_borrow.sv - (W+1)-bit ripple-borrow subtractor, diff = a - b
//   a, b : W+1-bit unsigned operands
//   diff : W+1-bit difference (modulo 2^(W+1))
//   bout : borrow out of the MSB cell; 1 means a < b
module sub_borrow #(
  parameter int W = 4
) (
  input  logic [W:0] a,
  input  logic [W:0] b,
  output logic [W:0] diff,
  output logic       bout
);

  // br[i] is the borrow into bit i; the chain starts with no borrow.
  logic [W+1:0] br;

  assign br[0] = 1'b0;

  for (genvar i = 0; i <= W; i++) begin : g_cell
    // One-bit full subtractor: d = a ^ b ^ bin, borrow when a < b + bin.
    assign diff[i]  = a[i] ^ b[i] ^ br[i];
    assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end

  assign bout = br[W+1];

endmodule

// File: rtl/div4_restoring.sv
// rtl/div4_restoring.sv - sequential restoring divider, one quotient bit per cycle
//   clk, rst    : clock and synchronous active-high reset
//   start       : request; honoured only in IDLE or DONE
//   dividend    : unsigned numerator, captured on an accepted start
//   divisor     : unsigned denominator, captured on an accepted start
//   busy        : high while iterating
//   done        : one-cycle pulse when results are published
//   quotient    : unsigned quotient, held until the next completion
//   remainder   : unsigned remainder, held until the next completion
//   div_by_zero : divisor was zero for the published result
module div4_restoring
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (W == DIV_W) ? CNT_W : $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  div_state_t state;
  div_state_t state_nxt;

  logic [CW-1:0] cnt;
  logic [W:0]    r;
  logic [W-1:0]  q;
  logic [W-1:0]  dv;
  logic          dbz_w;

  logic          accept;
  logic          last_iter;
  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic          bout;
  logic [W:0]    r_nxt;
  logic [W-1:0]  q_nxt;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (state == RUN) && (cnt == CNT_LAST);

  // ---------------- controller ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (cnt == CNT_LAST) state_nxt = DONE;
      DONE: state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == RUN && cnt != CNT_LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // ---------------- datapath ----------------
  // R stays below the divisor between iterations, so its top bit is always
  // zero and dropping it while shifting in the next dividend bit is lossless.
  assign shifted = (W + 1)'({r, q[W-1]});

  sub_borrow #(.W(W)) u_sub (
    .a    (shifted),
    .b    ({1'b0, dv}),
    .diff (trial),
    .bout (bout)
  );

  // Restore on borrow: keep the shifted value and record a 0 quotient bit.
  assign r_nxt = bout ? shifted : trial;
  assign q_nxt = {q[W-2:0], ~bout};

  always_ff @(posedge clk) begin
    if (rst) begin
      r     <= '0;
      q     <= '0;
      dv    <= '0;
      dbz_w <= 1'b0;
    end else if (accept) begin
      r     <= '0;
      q     <= dividend;
      dv    <= divisor;
      dbz_w <= (divisor == '0);
    end else if (state == RUN) begin
      r <= r_nxt;
      q <= q_nxt;
    end
  end

  // ---------------- published results ----------------
  // Loaded from the final iteration's next values on the RUN->DONE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (last_iter) begin
      quotient    <= q_nxt;
      remainder   <= r_nxt[W-1:0];
      div_by_zero <= dbz_w;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
